fir_sym_mac: RTL and testbench
==============================

# fir_sym_mac

Parametrised symmetric-coefficient FIR low-pass filter for the heart-rate front end. It sits between the SPI sample receiver and the peak detector/DAC path. It runs on the system clock instead of the SPI clock, with a valid-pulse handshake. Folded symmetric taps are time-multiplexed through one multiply-accumulate unit, and the result is rounded and saturated. Tap count, widths and coefficients are parameters.

## Interface
- DATA_W, 10: unsigned sample width, in and out.
- TAPS, 31: filter length; must be odd and ≥3. H = (TAPS+1)/2 folded taps.
- COEF_W, 8: unsigned coefficient width.
- FRAC_BITS, 10: coefficient scale; gain 1.0 = 2^FRAC_BITS.
- COEFS, fir_pkg::LP_COEFS_31: H coefficients c[0..H-1], where c[H-1] is the centre tap.

Ports:
- clk, in, 1: system clock. One clock domain; the reset is synchronous and active-high.
- reset, in, 1: synchronous, active-high.
- sample_valid, in, 1: one-cycle pulse; sample_in is valid in that cycle.
- sample_in, in, DATA_W: new sample.
- filt_en, in, 1: 1 = filter, 0 = bypass.
- clear, in, 1: synchronous flush of the delay line.
- busy, out, 1: MAC in progress; samples offered now are dropped.
- filt_valid, out, 1: one-cycle pulse marking a new filt_out.
- filt_out, out, DATA_W: filtered sample, held until the next update.
- overrun, out, 1: sticky flag; set when a sample is dropped, cleared by reset or clear.

## Operation
- Delay line x[0..TAPS-1], where x[0] is the newest. On an accepted sample, all entries shift by one and sample_in enters x[0]. This happens in both modes.
- FSM states are IDLE, MAC and ROUND.
- IDLE → MAC when sample_valid && filt_en. On the same edge: shift the delay line, set idx=0, set acc=0.
- MAC: each cycle does acc += c[idx]·(x[idx] + x[TAPS-1-idx]).
  - Exception: at idx = H-1 the term is c[H-1]·x[H-1], not doubled.
  - idx increments each cycle. After idx = H-1 the FSM goes to ROUND.
- ROUND: filt_out = sat(acc + 2^(FRAC_BITS-1)) >> FRAC_BITS. Saturation clamps to 2^DATA_W - 1. filt_valid pulses, then the FSM returns to IDLE.
- Accumulator width is DATA_W + 1 + COEF_W + clog2(H), so it never wraps.
- Bypass (filt_en = 0, FSM in IDLE): on sample_valid, shift the delay line, set filt_out = sample_in and pulse filt_valid on the next edge.
- filt_en is sampled only when a sample is accepted. Changing it during MAC has no effect on the sample in progress.
- sample_valid while busy: the sample is discarded, the delay line is untouched and overrun is set to 1.
- clear, reset and sample_valid in the same cycle: the sample is ignored.
- clear has priority over everything except reset:
  - Zeroes the delay line.
  - Aborts MAC/ROUND and returns to IDLE.
  - No filt_valid is produced for the aborted sample.
  - overrun = 0.
  - filt_out is retained.
- Reset values: filt_out = 0, filt_valid = 0, busy = 0, overrun = 0, delay line = 0, FSM = IDLE.
- reset mid-MAC: abort immediately; no output is produced.

## Timing
- Accepted sample_valid in cycle N (filter mode):
  - busy is high in cycles N+1 .. N+H+1.
  - filt_valid is high in cycle N+H+2 only, with filt_out updated in that cycle.
  - Latency is H+2 (18 with defaults).
- The next sample may be accepted in cycle N+H+2, the cycle filt_valid is high. Maximum throughput is one sample per H+2 cycles.
- Bypass: sample in cycle N → filt_valid and filt_out in cycle N+1. busy stays 0.
- filt_valid is always a single-cycle pulse; it is never high two cycles in a row in filter mode.

## Structure
- Package fir_pkg contains:
  - the state enum fir_state_t {IDLE, MAC, ROUND};
  - the coefficient array type coef_arr_t;
  - LP_COEFS_31 = {3,4,6,8,12,17,23,29,36,43,50,56,61,65,67,68}, with DC gain 1028/1024;
  - an accumulator-width function.
- Sub-module fir_delay_line (parametrised by DATA_W and TAPS) holds the shift, clear and dual read ports x[idx] and x[TAPS-1-idx]. The FSM, MAC and rounding stay in fir_sym_mac.

## Test plan
- Reset, then 40 samples of constant 1000 at one per 20 cycles (filter mode) → after the 31st sample, filt_out = 1004 on every filt_valid.
- Impulse of 1000 following zeros (TAPS = 31) → successive outputs are round(1000·c[k]/1024) in the order c[0..15], c[14..0]; the first output is 3.
- Constant 1023 → saturates; filt_out = 1023, never wraps to a low value.
- sample_valid pulses in cycles 0 and 5 → the second sample is dropped, overrun = 1, and exactly one filt_valid appears, in cycle 18.
- filt_en = 0 with sample 517 in cycle 0 → filt_valid and filt_out = 517 in cycle 1, busy = 0. filt_en toggled during MAC does not change that sample's result.
- clear asserted in cycle 7 of a MAC → no filt_valid and overrun = 0. A following impulse gives the clean impulse response.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, default coefficients and sizing helper for the symmetric FIR
package fir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, ROUND} fir_state_t;

    localparam int MAX_H = 64;

    // Folded coefficients c[0..H-1]; entries past H-1 are ignored by the filter.
    typedef int unsigned coef_arr_t [MAX_H];

    localparam coef_arr_t LP_COEFS_31 = '{
        0: 3,  1: 4,  2: 6,  3: 8,  4: 12, 5: 17, 6: 23, 7: 29,
        8: 36, 9: 43, 10: 50, 11: 56, 12: 61, 13: 65, 14: 67, 15: 68,
        default: 0
    };

    // Sized so a full pass of H folded products can never wrap.
    function automatic int acc_width(input int data_w, input int coef_w, input int h);
        return data_w + 1 + coef_w + $clog2(h);
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - sample shift register with flush and mirrored dual read ports
module fir_delay_line #(
    parameter int DATA_W = 10,
    parameter int TAPS   = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     shift,
    input  logic [DATA_W-1:0]        din,
    input  logic [$clog2(TAPS)-1:0]  idx,
    output logic [DATA_W-1:0]        x_lo,
    output logic [DATA_W-1:0]        x_hi
);

    localparam int TW = $clog2(TAPS);
    localparam logic [TW-1:0] LAST = TW'(TAPS - 1);

    logic [DATA_W-1:0] x [TAPS];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int k = 0; k < TAPS; k++) x[k] <= '0;
        end else if (shift) begin
            x[0] <= din;
            for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
        end
    end

    // x_lo/x_hi are the symmetric partners x[idx] and x[TAPS-1-idx].
    assign x_lo = x[idx];
    assign x_hi = x[LAST - idx];

endmodule

// File: rtl/fir_sym_mac.sv
// rtl/fir_sym_mac.sv - symmetric FIR low-pass, folded taps through one MAC, rounded and saturated
module fir_sym_mac
    import fir_pkg::*;
#(
    parameter int        DATA_W    = 10,
    parameter int        TAPS      = 31,
    parameter int        COEF_W    = 8,
    parameter int        FRAC_BITS = 10,
    parameter coef_arr_t COEFS     = LP_COEFS_31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              filt_en,
    input  logic              clear,
    output logic              busy,
    output logic              filt_valid,
    output logic [DATA_W-1:0] filt_out,
    output logic              overrun
);

    localparam int H  = (TAPS + 1) / 2;
    localparam int IW = $clog2(H);
    localparam int TW = $clog2(TAPS);
    localparam int AW = acc_width(DATA_W, COEF_W, H);
    localparam int PW = DATA_W + 1 + COEF_W;
    localparam logic [IW-1:0] LAST_IDX = IW'(H - 1);
    localparam logic [AW:0]   HALF     = (AW + 1)'(1) << (FRAC_BITS - 1);
    localparam logic [AW:0]   MAX_OUT  = (AW + 1)'({DATA_W{1'b1}});

    fir_state_t        state;
    logic [IW-1:0]     idx;
    logic [AW-1:0]     acc;
    logic [DATA_W-1:0] x_lo, x_hi;
    logic [COEF_W-1:0] coef_rom [H];
    logic [DATA_W:0]   pair;
    logic [PW-1:0]     term;
    logic [AW:0]       rounded, scaled;
    logic [DATA_W-1:0] sat_out;
    logic              shift;

    for (genvar k = 0; k < H; k++) begin : g_coef
        assign coef_rom[k] = COEF_W'(COEFS[k]);
    end

    assign shift = sample_valid && (state == IDLE) && !clear && !reset;

    fir_delay_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .shift (shift),
        .din   (sample_in),
        .idx   (TW'(idx)),
        .x_lo  (x_lo),
        .x_hi  (x_hi)
    );

    // The centre tap has no partner, so it is not doubled.
    assign pair    = (idx == LAST_IDX) ? {1'b0, x_lo} : {1'b0, x_lo} + {1'b0, x_hi};
    assign term    = PW'(coef_rom[idx]) * PW'(pair);
    assign rounded = (AW + 1)'(acc) + HALF;
    assign scaled  = rounded >> FRAC_BITS;
    assign sat_out = (scaled > MAX_OUT) ? {DATA_W{1'b1}} : scaled[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            busy       <= 1'b0;
            filt_valid <= 1'b0;
            filt_out   <= '0;
            overrun    <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            busy       <= 1'b0;
            filt_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            filt_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        if (filt_en) begin
                            state <= MAC;
                            busy  <= 1'b1;
                            idx   <= '0;
                            acc   <= '0;
                        end else begin
                            filt_out   <= sample_in;
                            filt_valid <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc <= acc + AW'(term);
                    if (idx == LAST_IDX) state <= ROUND;
                    else                 idx   <= idx + IW'(1);
                end
                ROUND: begin
                    filt_out   <= sat_out;
                    filt_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (sample_valid && state != IDLE) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fir_sym_mac.sv
// tb/tb_fir_sym_mac.sv - directed self-checking bench for fir_sym_mac with default parameters
module tb_fir_sym_mac;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic [9:0] sample_in = '0;
    logic       filt_en = 1'b1;
    logic       clear = 1'b0;
    logic       busy, filt_valid, overrun;
    logic [9:0] filt_out;

    int n_checks = 0;
    int n_fail   = 0;

    // round(1000*c[k]/1024) for the default coefficients, worked by hand
    int imp_exp [16] = '{3, 4, 6, 8, 12, 17, 22, 28, 35, 42, 49, 55, 60, 63, 65, 66};

    fir_sym_mac dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .filt_en      (filt_en),
        .clear        (clear),
        .busy         (busy),
        .filt_valid   (filt_valid),
        .filt_out     (filt_out),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        clear = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One filtered sample on a 20-cycle slot; returns result, latency and filt_valid one cycle later.
    task automatic filter_sample(input int v, output int res, output int lat, output logic nxt);
        sample_in = 10'(v);
        filt_en = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        lat = 1;
        while (filt_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        if (filt_valid !== 1'b1) check("filt_valid timeout", 0, 1);
        res = int'(filt_out);
        tick();
        nxt = filt_valid;
        for (int i = lat + 1; i < 20; i++) tick();
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (filt_valid === 1'b1) cnt++;
            tick();
        end
    endtask

    initial begin
        int res, lat, cnt, vcyc, c;
        logic nxt;

        do_reset();
        check("reset filt_out", filt_out, 0);
        check("reset filt_valid", filt_valid, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);

        // bypass: result appears one cycle later with busy low
        sample_in = 10'd517;
        filt_en = 1'b0;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("bypass filt_valid", filt_valid, 1);
        check("bypass filt_out", filt_out, 517);
        check("bypass busy", busy, 0);
        tick();
        check("bypass pulse width", filt_valid, 0);

        // filt_en dropped mid-MAC: 3*1000 + 4*517 = 5068 -> 5
        sample_in = 10'd1000;
        filt_en = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        filt_en = 1'b0;
        lat = 1;
        while (filt_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("toggle latency", lat, 18);
        check("toggle filt_out", filt_out, 5);
        filt_en = 1'b1;

        // dropped sample in cycle 5
        do_reset();
        sample_in = 10'd1000;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("busy cycle 1", busy, 1);
        repeat (4) tick();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("overrun set", overrun, 1);
        cnt = 0;
        vcyc = -1;
        for (c = 6; c < 32; c++) begin
            if (filt_valid === 1'b1) begin
                cnt++;
                vcyc = c;
            end
            if (c == 17) check("busy cycle 17", busy, 1);
            if (c == 18) check("busy cycle 18", busy, 0);
            tick();
        end
        check("overrun valid count", cnt, 1);
        check("overrun valid cycle", vcyc, 18);
        check("overrun sticky", overrun, 1);

        // constant 1000 -> 1000*1028/1024 rounds to 1004 once the line is full
        do_reset();
        for (int i = 0; i < 40; i++) begin
            filter_sample(1000, res, lat, nxt);
            if (i == 0) check("latency", lat, 18);
            if (i == 0) check("single pulse", nxt, 0);
            if (i >= 30) check($sformatf("dc1000 #%0d", i), res, 1004);
        end
        check("filt_out held", filt_out, 1004);

        // clear in cycle 7 of a MAC
        sample_in = 10'd1000;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("overrun before clear", overrun, 1);
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear overrun", overrun, 0);
        check("clear busy", busy, 0);
        count_valid(25, cnt);
        check("clear no valid", cnt, 0);
        check("clear keeps filt_out", filt_out, 1004);

        // impulse after clear
        for (int i = 0; i < 31; i++) begin
            filter_sample(i == 0 ? 1000 : 0, res, lat, nxt);
            check($sformatf("impulse #%0d", i), res, imp_exp[i <= 15 ? i : 30 - i]);
        end

        // 1023*1028/1024 exceeds full scale and must clamp
        do_reset();
        for (int i = 0; i < 36; i++) begin
            filter_sample(1023, res, lat, nxt);
            if (i >= 30) check($sformatf("sat #%0d", i), res, 1023);
        end

        // reset mid-MAC
        sample_in = 10'd300;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midmac reset filt_out", filt_out, 0);
        check("midmac reset busy", busy, 0);
        count_valid(25, cnt);
        check("midmac reset no valid", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
